// File: rtl/mem_wb_stage_if.sv
// MEM -> WB pipeline boundary bundle: MEM-side controls and data in,
// writeback-side register outputs and retirement counter out.
interface mem_wb_stage_if #(
   parameter int DATA_WIDTH = 32
);
   // Flow control: there is no ready. i_valid marks a real instruction in MEM.
   // i_stall holds the stage and i_flush turns the capture into a bubble. When
   // neither is set, the MEM contents are taken on the edge, whatever i_valid is.
   logic                  i_stall;
   logic                  i_flush;
   logic                  i_valid;
   logic [DATA_WIDTH-1:0] i_alu_result;
   logic [DATA_WIDTH-1:0] i_load_raw;
   logic [DATA_WIDTH-1:0] i_pc_plus4;
   logic [2:0]            i_funct3;
   logic [1:0]            i_result_src;
   logic [4:0]            i_rd;
   logic                  i_reg_write;

   logic [DATA_WIDTH-1:0] o_alu_result;
   logic [DATA_WIDTH-1:0] o_load_data;
   logic [DATA_WIDTH-1:0] o_pc_plus4;
   logic [1:0]            o_result_src;
   logic [4:0]            o_rd;
   logic                  o_reg_write;
   logic                  o_valid;
   logic [31:0]           o_retired_cnt;

   modport master (
      output i_stall, i_flush, i_valid, i_alu_result, i_load_raw, i_pc_plus4,
             i_funct3, i_result_src, i_rd, i_reg_write,
      input  o_alu_result, o_load_data, o_pc_plus4, o_result_src, o_rd,
             o_reg_write, o_valid, o_retired_cnt
   );

   modport slave (
      input  i_stall, i_flush, i_valid, i_alu_result, i_load_raw, i_pc_plus4,
             i_funct3, i_result_src, i_rd, i_reg_write,
      output o_alu_result, o_load_data, o_pc_plus4, o_result_src, o_rd,
             o_reg_write, o_valid, o_retired_cnt
   );
endinterface

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register. Load data is aligned and extended before capture,
// and retired instructions are counted.
module mem_wb_stage #(
   parameter int DATA_WIDTH = 32
) (
   input logic          i_clk,
   input logic          i_rst_n,
   mem_wb_stage_if.slave bus
);

   logic [1:0]            offset;
   logic [7:0]            byte_sel;
   logic [15:0]           half_sel;
   logic [DATA_WIDTH-1:0] load_aligned;
   logic [1:0]            result_src_next;

   logic [DATA_WIDTH-1:0] alu_result_q;
   logic [DATA_WIDTH-1:0] load_data_q;
   logic [DATA_WIDTH-1:0] pc_plus4_q;
   logic [1:0]            result_src_q;
   logic [4:0]            rd_q;
   logic                  reg_write_q;
   logic                  valid_q;
   logic [31:0]           retired_q;

   assign offset   = bus.i_alu_result[1:0];
   assign byte_sel = bus.i_load_raw[{offset, 3'b000} +: 8];
   // Halfword picks the upper or lower half only; offset[0] is ignored.
   assign half_sel = bus.i_load_raw[{offset[1], 4'b0000} +: 16];

   always_comb begin
      load_aligned = bus.i_load_raw;
      case (bus.i_funct3)
         3'b000:  load_aligned = {{(DATA_WIDTH-8){byte_sel[7]}}, byte_sel};
         3'b100:  load_aligned = {{(DATA_WIDTH-8){1'b0}}, byte_sel};
         3'b001:  load_aligned = {{(DATA_WIDTH-16){half_sel[15]}}, half_sel};
         3'b101:  load_aligned = {{(DATA_WIDTH-16){1'b0}}, half_sel};
         default: load_aligned = bus.i_load_raw;
      endcase
   end

   // The unused select encoding falls back to the ALU path.
   assign result_src_next = (bus.i_result_src == 2'b11) ? 2'b00 : bus.i_result_src;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         alu_result_q <= '0;
         load_data_q  <= '0;
         pc_plus4_q   <= '0;
         result_src_q <= 2'b00;
         rd_q         <= 5'd0;
         reg_write_q  <= 1'b0;
         valid_q      <= 1'b0;
         retired_q    <= 32'd0;
      end else begin
         // The WB instruction retires as it leaves, even when a flush follows.
         if (valid_q && !bus.i_stall)
            retired_q <= retired_q + 32'd1;

         if (bus.i_flush) begin
            valid_q     <= 1'b0;
            reg_write_q <= 1'b0;
         end else if (!bus.i_stall) begin
            alu_result_q <= bus.i_alu_result;
            load_data_q  <= load_aligned;
            pc_plus4_q   <= bus.i_pc_plus4;
            result_src_q <= result_src_next;
            rd_q         <= bus.i_rd;
            reg_write_q  <= bus.i_reg_write;
            valid_q      <= bus.i_valid;
         end
      end
   end

   assign bus.o_alu_result  = alu_result_q;
   assign bus.o_load_data   = load_data_q;
   assign bus.o_pc_plus4    = pc_plus4_q;
   assign bus.o_result_src  = result_src_q;
   assign bus.o_rd          = rd_q;
   // x0 is hardwired zero, so a write to it is suppressed here.
   assign bus.o_reg_write   = reg_write_q & valid_q & (rd_q != 5'd0);
   assign bus.o_valid       = valid_q;
   assign bus.o_retired_cnt = retired_q;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed bench for mem_wb_stage: reset, load alignment, stall/flush,
// write gating, counter wrap and back-to-back capture.
module tb_mem_wb_stage;

   logic clk;
   logic rst_n;
   int   checks = 0;
   int   errors = 0;

   mem_wb_stage_if #(.DATA_WIDTH(32)) bus ();

   mem_wb_stage #(.DATA_WIDTH(32)) dut (
      .i_clk   (clk),
      .i_rst_n (rst_n),
      .bus     (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Active edge, then sample 1 time unit later; inputs change after sampling.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_idle();
      bus.i_stall = 0; bus.i_flush = 0; bus.i_valid = 0;
      bus.i_alu_result = 0; bus.i_load_raw = 0; bus.i_pc_plus4 = 0;
      bus.i_funct3 = 0; bus.i_result_src = 0; bus.i_rd = 0; bus.i_reg_write = 0;
   endtask

   task automatic apply_reset();
      drive_idle();
      #2 rst_n = 1'b0;
      #3 rst_n = 1'b1;
      step();
   endtask

   task automatic test_reset();
      apply_reset();
      bus.i_valid = 1; bus.i_reg_write = 1; bus.i_rd = 5'd9; bus.i_result_src = 2'b10;
      bus.i_alu_result = 32'h0000_1234; bus.i_load_raw = 32'hDEAD_BEEF;
      bus.i_pc_plus4 = 32'h0000_0104; bus.i_funct3 = 3'b010;
      step();
      step();
      checks++; if (bus.o_retired_cnt !== 32'd1) begin errors++; $display("FAIL pre_reset_cnt: got %h expected %h", bus.o_retired_cnt, 32'd1); end
      // Reset mid-cycle with inputs still non-zero; no clock edge in between.
      #2 rst_n = 1'b0;
      #1;
      checks++; if (bus.o_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b expected 0", bus.o_valid); end
      checks++; if (bus.o_reg_write !== 1'b0) begin errors++; $display("FAIL rst_reg_write: got %b expected 0", bus.o_reg_write); end
      checks++; if (bus.o_rd !== 5'd0) begin errors++; $display("FAIL rst_rd: got %h expected 0", bus.o_rd); end
      checks++; if (bus.o_result_src !== 2'b00) begin errors++; $display("FAIL rst_result_src: got %b expected 00", bus.o_result_src); end
      checks++; if (bus.o_alu_result !== 32'd0) begin errors++; $display("FAIL rst_alu: got %h expected 0", bus.o_alu_result); end
      checks++; if (bus.o_load_data !== 32'd0) begin errors++; $display("FAIL rst_load: got %h expected 0", bus.o_load_data); end
      checks++; if (bus.o_pc_plus4 !== 32'd0) begin errors++; $display("FAIL rst_pc4: got %h expected 0", bus.o_pc_plus4); end
      checks++; if (bus.o_retired_cnt !== 32'd0) begin errors++; $display("FAIL rst_cnt: got %h expected 0", bus.o_retired_cnt); end
      // Reset held across an edge with stall and flush up must still win.
      bus.i_stall = 1; bus.i_flush = 1;
      step();
      checks++; if (bus.o_valid !== 1'b0 || bus.o_alu_result !== 32'd0) begin errors++; $display("FAIL rst_hold: got valid %b alu %h expected 0 0", bus.o_valid, bus.o_alu_result); end
      #2 rst_n = 1'b1;
      bus.i_stall = 0; bus.i_flush = 0;
      step();
      checks++; if (bus.o_alu_result !== 32'h0000_1234 || bus.o_valid !== 1'b1) begin errors++; $display("FAIL rst_first_capture: got alu %h valid %b expected 00001234 1", bus.o_alu_result, bus.o_valid); end
   endtask

   task automatic test_load_align();
      logic [2:0]  f3  [8] = '{3'b000, 3'b100, 3'b101, 3'b001, 3'b010, 3'b011, 3'b000, 3'b001};
      logic [31:0] adr [8] = '{32'h1003, 32'h1003, 32'h1002, 32'h1003, 32'h1001, 32'h1002, 32'h1000, 32'h1000};
      logic [31:0] exp [8] = '{32'hFFFF_FF80, 32'h0000_0080, 32'h0000_80FF, 32'hFFFF_80FF,
                               32'h80FF_7F01, 32'h80FF_7F01, 32'h0000_0001, 32'h0000_7F01};
      apply_reset();
      bus.i_load_raw = 32'h80FF_7F01; bus.i_valid = 1; bus.i_result_src = 2'b01;
      for (int i = 0; i < 8; i++) begin
         bus.i_funct3 = f3[i]; bus.i_alu_result = adr[i];
         step();
         checks++;
         if (bus.o_load_data !== exp[i]) begin
            errors++; $display("FAIL load_align[%0d] f3=%b addr=%h: got %h expected %h", i, f3[i], adr[i], bus.o_load_data, exp[i]);
         end
      end
   endtask

   task automatic test_stall_flush();
      apply_reset();
      bus.i_valid = 1; bus.i_reg_write = 1; bus.i_rd = 5'd5; bus.i_alu_result = 32'h0000_AAAA;
      step();
      checks++; if (bus.o_rd !== 5'd5 || bus.o_reg_write !== 1'b1 || bus.o_valid !== 1'b1) begin errors++; $display("FAIL sf_capture: got rd %0d rw %b v %b expected 5 1 1", bus.o_rd, bus.o_reg_write, bus.o_valid); end
      checks++; if (bus.o_retired_cnt !== 32'd0) begin errors++; $display("FAIL sf_cnt0: got %0d expected 0", bus.o_retired_cnt); end
      bus.i_stall = 1; bus.i_rd = 5'd7; bus.i_alu_result = 32'h0000_5555;
      for (int i = 0; i < 3; i++) begin
         step();
         checks++;
         if (bus.o_rd !== 5'd5 || bus.o_alu_result !== 32'h0000_AAAA || bus.o_retired_cnt !== 32'd0) begin
            errors++; $display("FAIL sf_stall[%0d]: got rd %0d alu %h cnt %0d expected 5 0000aaaa 0", i, bus.o_rd, bus.o_alu_result, bus.o_retired_cnt);
         end
      end
      bus.i_stall = 0;
      step();
      checks++; if (bus.o_retired_cnt !== 32'd1 || bus.o_rd !== 5'd7) begin errors++; $display("FAIL sf_unstall: got cnt %0d rd %0d expected 1 7", bus.o_retired_cnt, bus.o_rd); end
      bus.i_stall = 1; bus.i_flush = 1;
      step();
      checks++; if (bus.o_valid !== 1'b0 || bus.o_reg_write !== 1'b0) begin errors++; $display("FAIL sf_flush_stall: got v %b rw %b expected 0 0", bus.o_valid, bus.o_reg_write); end
      checks++; if (bus.o_rd !== 5'd7 || bus.o_retired_cnt !== 32'd1) begin errors++; $display("FAIL sf_flush_hold: got rd %0d cnt %0d expected 7 1", bus.o_rd, bus.o_retired_cnt); end
      bus.i_stall = 0; bus.i_flush = 0; bus.i_rd = 5'd8;
      step();
      bus.i_flush = 1;
      step();
      checks++; if (bus.o_valid !== 1'b0 || bus.o_retired_cnt !== 32'd2 || bus.o_rd !== 5'd8) begin errors++; $display("FAIL sf_flush_retire: got v %b cnt %0d rd %0d expected 0 2 8", bus.o_valid, bus.o_retired_cnt, bus.o_rd); end
      bus.i_flush = 0;
   endtask

   task automatic test_gating();
      apply_reset();
      bus.i_valid = 1; bus.i_reg_write = 1; bus.i_rd = 5'd0; bus.i_result_src = 2'b11;
      step();
      checks++; if (bus.o_reg_write !== 1'b0 || bus.o_valid !== 1'b1) begin errors++; $display("FAIL gate_rd0: got rw %b v %b expected 0 1", bus.o_reg_write, bus.o_valid); end
      checks++; if (bus.o_result_src !== 2'b00) begin errors++; $display("FAIL gate_src11: got %b expected 00", bus.o_result_src); end
      bus.i_valid = 0; bus.i_rd = 5'd3; bus.i_result_src = 2'b10; bus.i_pc_plus4 = 32'h0000_0040;
      step();
      checks++; if (bus.o_reg_write !== 1'b0 || bus.o_valid !== 1'b0) begin errors++; $display("FAIL gate_bubble: got rw %b v %b expected 0 0", bus.o_reg_write, bus.o_valid); end
      checks++; if (bus.o_rd !== 5'd3 || bus.o_pc_plus4 !== 32'h40 || bus.o_result_src !== 2'b10) begin errors++; $display("FAIL gate_bubble_data: got rd %0d pc4 %h src %b expected 3 00000040 10", bus.o_rd, bus.o_pc_plus4, bus.o_result_src); end
      bus.i_valid = 1; bus.i_reg_write = 0;
      step();
      checks++; if (bus.o_reg_write !== 1'b0) begin errors++; $display("FAIL gate_no_write: got %b expected 0", bus.o_reg_write); end
      bus.i_reg_write = 1;
      step();
      checks++; if (bus.o_reg_write !== 1'b1) begin errors++; $display("FAIL gate_write: got %b expected 1", bus.o_reg_write); end
   endtask

   task automatic test_counter_wrap();
      apply_reset();
      bus.i_valid = 1;
      step();
      #1 force dut.retired_q = 32'hFFFF_FFFE;
      #1 release dut.retired_q;
      step();
      checks++; if (bus.o_retired_cnt !== 32'hFFFF_FFFF) begin errors++; $display("FAIL wrap_max: got %h expected ffffffff", bus.o_retired_cnt); end
      step();
      checks++; if (bus.o_retired_cnt !== 32'h0000_0000) begin errors++; $display("FAIL wrap_zero: got %h expected 00000000", bus.o_retired_cnt); end
   endtask

   task automatic test_back_to_back();
      logic [1:0] src [4] = '{2'b00, 2'b01, 2'b10, 2'b00};
      apply_reset();
      for (int i = 0; i < 4; i++) begin
         bus.i_valid = 1; bus.i_reg_write = 1; bus.i_rd = 5'(i + 1);
         bus.i_result_src = src[i]; bus.i_pc_plus4 = 32'h100 + 32'(4 * i);
         step();
         checks++;
         if (bus.o_result_src !== src[i] || bus.o_rd !== 5'(i + 1) || bus.o_pc_plus4 !== 32'h100 + 32'(4 * i)) begin
            errors++; $display("FAIL b2b[%0d]: got src %b rd %0d pc4 %h expected %b %0d %h", i, bus.o_result_src, bus.o_rd, bus.o_pc_plus4, src[i], i + 1, 32'h100 + 32'(4 * i));
         end
      end
      bus.i_valid = 0; bus.i_reg_write = 0;
      step();
      checks++; if (bus.o_retired_cnt !== 32'd4) begin errors++; $display("FAIL b2b_cnt: got %0d expected 4", bus.o_retired_cnt); end
   endtask

   initial begin
      rst_n = 1'b0;
      drive_idle();
      #12 rst_n = 1'b1;
      test_reset();
      test_load_align();
      test_stall_flush();
      test_gating();
      test_counter_wrap();
      test_back_to_back();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/mem_wb_stage.md
MEM_WB_STAGE -- requirements
Module: mem_wb_stage

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, width of all data/address buses.
REQ-002 SHALL have port i_clk, input, 1, the only clock; all state updates on rising edge.
REQ-003 SHALL have port i_rst_n, input, 1, reset, asynchronous and active-low.
REQ-004 SHALL have port i_stall, input, 1, hold all stage registers.
REQ-005 SHALL have port i_flush, input, 1, insert a bubble instead of capturing.
REQ-006 SHALL have port i_valid, input, 1, a real instruction is present in MEM.
REQ-007 SHALL have port i_alu_result, input, DATA_WIDTH, ALU result / load effective address.
REQ-008 SHALL have port i_load_raw, input, DATA_WIDTH, raw aligned word from data memory.
REQ-009 SHALL have port i_pc_plus4, input, DATA_WIDTH, PC+4 for JAL/JALR link.
REQ-010 SHALL have port i_funct3, input, 3, load type.
REQ-011 SHALL have port i_result_src, input, 2, writeback source select.
REQ-012 SHALL have port i_rd, input, 5, destination register index.
REQ-013 SHALL have port i_reg_write, input, 1, instruction writes rd.
REQ-014 SHALL have outputs o_alu_result, o_load_data, o_pc_plus4 (each DATA_WIDTH) feeding the 3:1 writeback result mux data inputs a/b/c.
REQ-015 SHALL have output o_result_src, 2, driving the result mux select.
REQ-016 SHALL have outputs o_rd (5), o_reg_write (1), o_valid (1), o_retired_cnt (32).

Function
REQ-017 Capture priority per edge SHALL be: flush > stall > load.
REQ-018 On flush: valid_q <= 0, reg_write_q <= 0; data registers hold their values.
REQ-019 On stall without flush: every register, including the counter, except as REQ-026 allows, SHALL hold.
REQ-020 Otherwise: all inputs SHALL be registered; latency exactly 1 cycle MEM -> WB.
REQ-021 o_valid SHALL equal registered i_valid.
REQ-022 o_reg_write SHALL equal reg_write_q AND valid_q AND (rd_q != 0), combinational from registers.
REQ-023 Load alignment SHALL be computed before the register from offset = i_alu_result[1:0]: LB(000)/LBU(100) select byte[offset]; LH(001)/LHU(101) select half[offset[1]], ignoring offset[0]; LW(010) passes the full word.
REQ-024 LB/LH SHALL sign-extend; LBU/LHU SHALL zero-extend; funct3 011/110/111 SHALL pass the raw word unchanged.
REQ-025 i_result_src 00/01/10 SHALL be registered as given; 11 SHALL be registered as 00 (ALU).
REQ-026 o_retired_cnt SHALL increment by 1 on each edge where valid_q=1 and i_stall=0, and flush does not block it.
REQ-027 o_retired_cnt SHALL wrap from 0xFFFFFFFF to 0 with no flag.
REQ-028 i_valid=0 captures SHALL still register data (a bubble); only valid_q gates side effects.
REQ-029 Simultaneous flush and stall SHALL produce a bubble (flush wins); the counter still follows REQ-026.

Reset
REQ-030 While i_rst_n=0, all registers and outputs SHALL be 0 immediately, independent of i_clk.
REQ-031 Reset asserted mid-stall or mid-flush SHALL override both; the first capture SHALL occur on the first rising edge with i_rst_n=1.

Verification
REQ-032 Reset: drive inputs non-zero, pulse i_rst_n low between edges -> all outputs 0 without a clock edge; counter 0.
REQ-033 Load align: i_alu_result=0x1003, i_load_raw=0x80FF7F01, funct3=000 -> o_load_data=0xFFFFFF80 next cycle; funct3=100 -> 0x00000080; funct3=101 at offset 2 -> 0x000080FF; funct3=001 at offset 3 -> 0xFFFF80FF.
REQ-034 Stall/flush: capture rd=5, reg_write=1, valid=1; stall 3 cycles -> outputs held, counter +1 only on the final unstalled edge; assert flush and stall together -> o_valid=0, o_reg_write=0 next cycle.
REQ-035 Gating: rd=0, reg_write=1, valid=1 -> o_reg_write=0; result_src=11 -> o_result_src=00.
REQ-036 Counter wrap: force 0xFFFFFFFE, run 2 valid unstalled cycles -> 0xFFFFFFFF, then 0x00000000.
REQ-037 Back-to-back: 4 valid instructions with result_src 00,01,10,00 on consecutive cycles -> o_result_src shows the same sequence 1 cycle later, counter reaches 4.
